// File: rtl/score_render.sv
// N-digit decimal score renderer: binary score is converted to BCD once per
// frame by a serial double-dabble engine, then drawn as seven-segment glyphs.
module score_render #(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned SCORE_W    = 17,
  parameter int unsigned X0         = 20,
  parameter int unsigned Y0         = 70,
  parameter int unsigned PITCH      = 26,
  parameter int unsigned BAR_W      = 10,
  parameter int unsigned GAP_W      = 5,
  parameter int unsigned SEG_H      = 10,
  parameter int unsigned GAP_H      = 5,
  parameter int unsigned BLANK_LEAD = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         col,
  input  logic [9:0]         row,
  input  logic               valid,
  input  logic [5:0]         digit_color,
  output logic [5:0]         digit_rgb,
  output logic               busy,
  output logic               overflow
);

  localparam int unsigned DIGIT_W = 2*BAR_W + GAP_W;
  localparam int unsigned BCD_W   = 4*NUM_DIGITS;
  localparam int unsigned CNT_W   = $clog2(SCORE_W + 1);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]           MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(SCORE_W - 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS'(1));

  // segment order {a,b,c,d,e,f,g}
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_n;
  logic [SCORE_W-1:0]     bin_q;
  logic [BCD_W-1:0]       acc_q, acc_adj;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sat_q, pending;
  logic [BCD_W-1:0]       disp_q;
  logic [NUM_DIGITS-1:0]  blank_q, blank_n;
  logic                   load, step, commit;
  logic                   sat_in;
  logic [SCORE_W-1:0]     load_val;

  assign sat_in   = 64'(score) > MAX_VAL;
  assign load_val = sat_in ? MAX_VAL[SCORE_W-1:0] : score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A pulse arriving during COMMIT restarts directly, same as a pending one.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt_q == LAST_CNT) state_n = COMMIT;
      end
      COMMIT: begin
        commit = 1'b1;
        if (pending || frame_start) begin
          load    = 1'b1;
          state_n = SHIFT;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
  end

  // Leading-zero mask: a digit is blank until a nonzero digit is seen above it.
  always_comb begin
    logic seen;
    int unsigned i;
    seen    = 1'b0;
    blank_n = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      i = NUM_DIGITS - 1 - j;
      seen = seen | (acc_q[4*i +: 4] != 4'd0);
      blank_n[i] = !seen && (i != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      pending  <= 1'b0;
      disp_q   <= '0;
      blank_q  <= BLANK_RST;
      overflow <= 1'b0;
    end else begin
      if (commit) begin
        disp_q   <= acc_q;
        blank_q  <= blank_n;
        overflow <= sat_q;
      end
      if (load) begin
        bin_q <= load_val;
        acc_q <= '0;
        cnt_q <= '0;
        sat_q <= sat_in;
      end else if (step) begin
        acc_q <= {acc_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state == COMMIT)                    pending <= 1'b0;
      else if (frame_start && state != IDLE) pending <= 1'b1;
    end
  end

  logic show;

  always_comb begin
    int unsigned cu, ru, lc, base;
    logic        hit, sel_blank, left, right, lit;
    logic [3:0]  nib;
    logic [6:0]  sg;
    cu        = 32'(col);
    ru        = 32'(row);
    lc        = 0;
    hit       = 1'b0;
    sel_blank = 1'b0;
    nib       = 4'd0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      base = X0 + k*PITCH;
      if (cu > base && cu <= base + DIGIT_W) begin
        hit       = 1'b1;
        lc        = cu - base;
        nib       = disp_q[4*(NUM_DIGITS-1-k) +: 4];
        sel_blank = blank_q[NUM_DIGITS-1-k];
      end
    end
    sg    = seg_decode(nib);
    left  = lc <= BAR_W;
    right = lc > BAR_W + GAP_W;
    lit   = 1'b0;
    if (ru > Y0) begin
      if (ru <= Y0 + SEG_H)
        lit = sg[6] | (left & sg[1]) | (right & sg[5]);
      else if (ru <= Y0 + SEG_H + GAP_H)
        lit = (left & sg[1]) | (right & sg[5]);
      else if (ru <= Y0 + 2*SEG_H + GAP_H)
        lit = sg[0] | (left & (sg[1] | sg[2])) | (right & (sg[5] | sg[4]));
      else if (ru <= Y0 + 2*SEG_H + 2*GAP_H)
        lit = (left & sg[2]) | (right & sg[4]);
      else if (ru <= Y0 + 3*SEG_H + 2*GAP_H)
        lit = sg[3] | (left & sg[2]) | (right & sg[4]);
    end
    show = valid & hit & lit & !((BLANK_LEAD != 0) && sel_blank);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_rgb <= '0;
    else     digit_rgb <= show ? digit_color : '0;
  end

endmodule
